// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [31:0] NopInst     = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[31:2] + 30'd1, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory req/ack bus between the fetch stage and memory.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   inst_req;
  logic [InstAddrBus-1:0] inst_addr;
  logic                   inst_ack;
  logic [InstBus-1:0]     inst_rdata;

  modport master (output inst_req, inst_addr, input  inst_ack, inst_rdata);
  modport slave  (input  inst_req, inst_addr, output inst_ack, inst_rdata);
endinterface

// File: rtl/if_fetch_if_id.sv
// IF/ID pipeline register: holds on stall, clears on flush.
module if_fetch_if_id
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] ld_pc_i,
  input  logic [31:0] ld_inst_i,
  input  logic        ld_valid_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      id_pc_q    <= ZeroWord;
      id_inst_q  <= NopInst;
      id_valid_q <= 1'b0;
    end else if (flush_i) begin
      id_pc_q    <= ZeroWord;
      id_inst_q  <= NopInst;
      id_valid_q <= 1'b0;
    end else if (!stall_i) begin
      id_pc_q    <= ld_pc_i;
      id_inst_q  <= ld_valid_i ? ld_inst_i : NopInst;
      id_valid_q <= ld_valid_i;
    end
  end

  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: PC, req/ack FSM, stall buffer, delayed-branch redirect and flush.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              flush_i,
  input  logic [31:0]       flush_pc_i,
  if_fetch_if.master        mem,
  output logic [31:0]       id_pc_o,
  output logic [31:0]       id_inst_o,
  output logic              id_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;

  logic [31:0]  ld_pc, ld_inst;
  logic         ld_valid;
  logic         redir;
  logic [31:0]  redir_pc, seq_pc;

  // A redirect sampled during a stall is re-presented by decode later.
  assign redir    = redirect_i && !stall_i;
  assign redir_pc = word_align(redirect_pc_i);
  assign seq_pc   = redir  ? redir_pc  :
                    pend_q ? pend_pc_q : pc_inc(pc_q);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    ld_pc       = ZeroWord;
    ld_inst     = NopInst;
    ld_valid    = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (mem.inst_ack) begin
          pc_d   = seq_pc;
          pend_d = 1'b0;
          if (stall_i) begin
            hold_pc_d   = pc_q;
            hold_inst_d = mem.inst_rdata;
            state_d     = ST_HOLD;
          end else begin
            ld_pc    = pc_q;
            ld_inst  = mem.inst_rdata;
            ld_valid = 1'b1;
          end
        end else if (redir) begin
          pend_d    = 1'b1;
          pend_pc_d = redir_pc;
        end
      end
      ST_HOLD: begin
        // pc already points past the buffered delay slot
        if (redir) pc_d = redir_pc;
        if (!stall_i) begin
          ld_pc    = hold_pc_q;
          ld_inst  = hold_inst_q;
          ld_valid = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_DROP: if (mem.inst_ack) state_d = ST_REQ;
      default: state_d = ST_BOOT;
    endcase

    if (flush_i) begin
      pc_d        = word_align(flush_pc_i);
      pend_d      = 1'b0;
      pend_pc_d   = ZeroWord;
      hold_pc_d   = ZeroWord;
      hold_inst_d = NopInst;
      if (state_q == ST_REQ && !mem.inst_ack) begin
        state_d     = ST_DROP;
        drop_addr_d = pc_q;
      end else if (state_q != ST_DROP) begin
        state_d = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      hold_pc_q   <= ZeroWord;
      hold_inst_q <= NopInst;
      pend_q      <= 1'b0;
      pend_pc_q   <= ZeroWord;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
    end
  end

  // DROP keeps presenting the abandoned address until memory acks it.
  assign mem.inst_req  = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign mem.inst_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  if_fetch_if_id u_if_id (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .ld_pc_i    (ld_pc),
    .ld_inst_i  (ld_inst),
    .ld_valid_i (ld_valid),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_valid_o (id_valid_o)
  );

endmodule
